// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Streams a program into shared memory, verifies it against a
//            shadow copy, then hands the bus back and kicks the fetcher.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8,
    parameter int BASE_ADDR  = 16,
    parameter int LOAD_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_WIDTH-1:0]  byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_dout,
    output logic                  mem_we,
    input  logic [REG_WIDTH-1:0]  mem_din,
    output logic                  manual_mem,
    output logic                  trigger_program,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] error_addr
);

    localparam int PTR_W = $clog2(LOAD_LEN + 1);
    localparam int IDX_W = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_base = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [PTR_W-1:0]      c_last = PTR_W'(LOAD_LEN - 1);
    localparam logic [PTR_W-1:0]      c_len  = PTR_W'(LOAD_LEN);
    localparam logic [PTR_W-1:0]      c_one  = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_VERIFY  = 3'd2,
        S_TRIGGER = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [REG_WIDTH-1:0] r_shadow [LOAD_LEN];

    logic                  w_accept;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_ptr_addr;
    logic [ADDR_WIDTH-1:0] w_chk_addr;
    logic                  w_mismatch;

    assign w_accept   = (r_state == S_LOAD) && byte_valid && byte_ready;
    assign w_wr_idx   = r_ptr[IDX_W-1:0];
    // Readback data lags the issued address by one cycle, so compare entry ptr-1.
    assign w_rd_idx   = IDX_W'(r_ptr - c_one);
    assign w_ptr_addr = c_base + ADDR_WIDTH'(r_ptr);
    assign w_chk_addr = c_base + ADDR_WIDTH'(r_ptr - c_one);
    assign w_mismatch = (mem_din != r_shadow[w_rd_idx]);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow[w_wr_idx] <= byte_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            byte_ready      <= 1'b0;
            mem_addr        <= '0;
            mem_dout        <= '0;
            mem_we          <= 1'b0;
            manual_mem      <= 1'b0;
            trigger_program <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            error_addr      <= '0;
        end else begin
            mem_we          <= 1'b0;
            trigger_program <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        byte_ready <= 1'b1;
                        manual_mem <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        error_addr <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        mem_addr <= w_ptr_addr;
                        mem_dout <= byte_in;
                        mem_we   <= 1'b1;
                        if (r_ptr == c_last) begin
                            r_state    <= S_VERIFY;
                            r_ptr      <= '0;
                            byte_ready <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + c_one;
                        end
                    end
                end
                S_VERIFY: begin
                    if ((r_ptr != '0) && w_mismatch) begin
                        r_state    <= S_ERROR;
                        error      <= 1'b1;
                        error_addr <= w_chk_addr;
                    end else if (r_ptr == c_len) begin
                        r_state         <= S_TRIGGER;
                        trigger_program <= 1'b1;
                        manual_mem      <= 1'b0;
                    end else begin
                        mem_addr <= w_ptr_addr;
                        r_ptr    <= r_ptr + c_one;
                    end
                end
                S_TRIGGER: begin
                    r_state <= S_DONE;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Self-checking bench for prog_loader with a sync-write /
//            async-read memory model; instance 1 uses a wrapping base address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       start = '0;
    logic [1:0]       byte_valid = '0;
    logic [1:0][7:0]  byte_in = '0;
    logic [1:0]       corrupt = '0;
    logic [1:0]       byte_ready;
    logic [1:0][15:0] mem_addr;
    logic [1:0][7:0]  mem_dout;
    logic [1:0]       mem_we;
    logic [1:0][7:0]  mem_din;
    logic [1:0]       manual_mem;
    logic [1:0]       trigger_program;
    logic [1:0]       done;
    logic [1:0]       error;
    logic [1:0][15:0] error_addr;

    logic [7:0] mem [2][65536];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        prog_loader #(
            .ADDR_WIDTH (16),
            .REG_WIDTH  (8),
            .BASE_ADDR  ((g == 0) ? 16 : 32'hFFF8),
            .LOAD_LEN   (16)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .start           (start[g]),
            .byte_in         (byte_in[g]),
            .byte_valid      (byte_valid[g]),
            .byte_ready      (byte_ready[g]),
            .mem_addr        (mem_addr[g]),
            .mem_dout        (mem_dout[g]),
            .mem_we          (mem_we[g]),
            .mem_din         (mem_din[g]),
            .manual_mem      (manual_mem[g]),
            .trigger_program (trigger_program[g]),
            .done            (done[g]),
            .error           (error[g]),
            .error_addr      (error_addr[g])
        );
        // Fault injection: location 0x12 reads back as 0xFF when corrupt is set.
        assign mem_din[g] = (corrupt[g] && mem_addr[g] == 16'h0012) ? 8'hFF
                                                                    : mem[g][mem_addr[g]];
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d] && manual_mem[d]) mem[d][mem_addr[d]] <= mem_dout[d];
        end
    end

    // Bus monitor: logs write/read addresses and counts verify cycles and triggers.
    int         wr_tot [2]   = '{0, 0};
    int         rd_tot [2]   = '{0, 0};
    int         vf_tot [2]   = '{0, 0};
    int         trig_tot [2] = '{0, 0};
    int         trig_bad [2] = '{0, 0};
    logic       trig_prev [2] = '{1'b0, 1'b0};
    logic [15:0] wr_log [2][64];
    logic [15:0] rd_log [2][64];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) begin
                wr_log[d][6'(wr_tot[d])] <= mem_addr[d];
                wr_tot[d] <= wr_tot[d] + 1;
            end
            if (manual_mem[d] && !byte_ready[d] && !error[d]) begin
                vf_tot[d] <= vf_tot[d] + 1;
                if (!mem_we[d]) begin
                    rd_log[d][6'(rd_tot[d])] <= mem_addr[d];
                    rd_tot[d] <= rd_tot[d] + 1;
                end
            end
            if (trigger_program[d]) begin
                trig_tot[d] <= trig_tot[d] + 1;
                if (manual_mem[d] || done[d] || error[d]) trig_bad[d] <= trig_bad[d] + 1;
            end
            if (trig_prev[d] && !done[d]) trig_bad[d] <= trig_bad[d] + 1;
            trig_prev[d] <= trigger_program[d];
        end
    end

    logic [7:0] prog [16];

    typedef struct {
        int          d;
        logic [31:0] pat;
        bit          sim_valid;
        bit          corrupt;
        int          ign_load;
        int          ign_verify;
        bit          exp_err;
        logic [15:0] exp_eaddr;
        int          exp_trig;
        int          exp_wr;
        int          exp_vf;
        int          exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] base_of(input int d);
        return (d == 0) ? 16'h0010 : 16'hFFF8;
    endfunction

    function automatic logic [45:0] out_vec(input int d);
        return {mem_addr[d], mem_dout[d], mem_we[d], byte_ready[d], manual_mem[d],
                trigger_program[d], done[d], error[d], error_addr[d]};
    endfunction

    task automatic do_start(input int d, input bit with_valid);
        @(posedge clk); #1;
        start[d]      = 1'b1;
        byte_valid[d] = with_valid;
        byte_in[d]    = prog[0];
        if (with_valid) chk("idle_ready_low", byte_ready[d], 1'b0);
        @(posedge clk); #1;
        start[d]      = 1'b0;
        byte_valid[d] = 1'b0;
        if (with_valid) begin
            chk("idle_byte_not_taken", mem_we[d], 1'b0);
            chk("ready_after_start", byte_ready[d], 1'b1);
        end
    endtask

    task automatic stream(input int d, input logic [31:0] pat, input int ign);
        int  idx = 0;
        int  cyc = 0;
        bit  hs;
        while (idx < 16 && cyc < 200) begin
            byte_valid[d] = pat[cyc % 32];
            byte_in[d]    = prog[idx];
            start[d]      = (cyc == ign);
            hs = byte_valid[d] && byte_ready[d];
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        byte_valid[d] = 1'b0;
        start[d]      = 1'b0;
        chk("stream_complete", 64'(idx), 64'd16);
    endtask

    task automatic wait_end(input int d, input int ign);
        for (int c = 0; c < 100; c++) begin
            start[d] = (c == ign);
            @(posedge clk); #1;
            if (done[d] || error[d]) break;
        end
        start[d] = 1'b0;
        chk("end_reached", 64'(done[d] | error[d]), 64'd1);
        @(negedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        int w0 = wr_tot[v.d];
        int r0 = rd_tot[v.d];
        int f0 = vf_tot[v.d];
        int t0 = trig_tot[v.d];
        int b0 = trig_bad[v.d];
        int bad;
        logic [15:0] base = base_of(v.d);
        corrupt[v.d] = v.corrupt;
        do_start(v.d, v.sim_valid);
        stream(v.d, v.pat, v.ign_load);
        wait_end(v.d, v.ign_verify);
        chk("error", error[v.d], v.exp_err);
        chk("error_addr", error_addr[v.d], v.exp_eaddr);
        chk("done", done[v.d], !v.exp_err);
        chk("manual_mem", manual_mem[v.d], v.exp_err);
        chk("trigger_count", 64'(trig_tot[v.d] - t0), 64'(v.exp_trig));
        chk("trigger_shape", 64'(trig_bad[v.d] - b0), 64'd0);
        chk("write_count", 64'(wr_tot[v.d] - w0), 64'(v.exp_wr));
        chk("verify_cycles", 64'(vf_tot[v.d] - f0), 64'(v.exp_vf));
        chk("read_count", 64'(rd_tot[v.d] - r0), 64'(v.exp_rd));
        bad = 0;
        for (int j = 0; j < v.exp_wr; j++)
            if (wr_log[v.d][6'(w0 + j)] !== 16'(base + 16'(j))) bad++;
        chk("write_addr_seq", 64'(bad), 64'd0);
        bad = 0;
        for (int j = 0; j < v.exp_rd; j++)
            if (rd_log[v.d][6'(r0 + j)] !== 16'(base + 16'(j))) bad++;
        chk("read_addr_seq", 64'(bad), 64'd0);
        bad = 0;
        for (int j = 0; j < 16; j++)
            if (mem[v.d][16'(base + 16'(j))] !== prog[j]) bad++;
        chk("mem_image", 64'(bad), 64'd0);
        corrupt[v.d] = 1'b0;
    endtask

    initial begin : main
        vec_t tbl [6];
        vec_t clean0;
        prog[0] = 8'hA9; prog[1] = 8'h04; prog[2] = 8'h85; prog[3] = 8'h02;
        for (int j = 4; j < 16; j++) prog[j] = 8'h00;

        //         d  pattern        simv corr ignL ignV err eaddr     trig wr  vf  rd
        tbl[0] = '{0, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, -1, 1'b0, 16'h0000, 1, 16, 17, 16};
        tbl[1] = '{0, 32'h4B59_A6C9, 1'b0, 1'b0, -1, -1, 1'b0, 16'h0000, 1, 16, 17, 16};
        tbl[2] = '{0, 32'hFFFF_FFFF, 1'b0, 1'b1, -1, -1, 1'b1, 16'h0012, 0, 16,  4,  3};
        tbl[3] = '{0, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, -1, 1'b0, 16'h0000, 1, 16, 17, 16};
        tbl[4] = '{1, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, -1, 1'b0, 16'h0000, 1, 16, 17, 16};
        tbl[5] = '{0, 32'hFFFF_FFFF, 1'b0, 1'b0,  5,  3, 1'b0, 16'h0000, 1, 16, 17, 16};
        clean0 = tbl[3];

        #1 reset = 1'b1;
        #2;
        chk("reset_outputs_dut0", 64'(out_vec(0)), 64'd0);
        chk("reset_outputs_dut1", 64'(out_vec(1)), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Reset in the middle of a load, after five accepted bytes.
        do_start(0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            byte_valid[0] = 1'b1;
            byte_in[0]    = prog[j];
            @(posedge clk); #1;
        end
        chk("midload_writing", mem_we[0], 1'b1);
        reset = 1'b1;
        byte_valid[0] = 1'b0;
        #1;
        chk("midload_reset_outputs", 64'(out_vec(0)), 64'd0);
        @(negedge clk) reset = 1'b0;
        run_vec(clean0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side master for the shared program memory: accepts a byte stream over a valid/ready handshake and writes it to consecutive addresses starting at BASE_ADDR.
- Reads the written region back and compares it against an internal shadow copy.
- On a clean compare, releases the memory bus and pulses trigger_program to start the fetcher.
- Replaces hand-driven memory loading and the trigger sequence in system benches and on the board.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- REG_WIDTH, 8, data byte width.
- BASE_ADDR, 16, first memory address written.
- LOAD_LEN, 16, bytes per load (1..256); also the shadow buffer depth.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERROR.
- byte_in  in  REG_WIDTH  stream data.
- byte_valid  in  1  stream data valid.
- byte_ready  out  1  loader can accept a byte.
- mem_addr  out  ADDR_WIDTH  memory address, registered.
- mem_dout  out  REG_WIDTH  memory write data, registered.
- mem_we  out  1  memory write enable, registered.
- mem_din  in  REG_WIDTH  memory read data, valid one clk after address with mem_we=0.
- manual_mem  out  1  loader owns the memory bus (selects loader addr/data/we over the fetcher).
- trigger_program  out  1  one-cycle pulse to the fetcher get_next.
- done  out  1  load verified and program triggered.
- error  out  1  readback mismatch.
- error_addr  out  ADDR_WIDTH  address of the first mismatch.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, ptr=0. Memory contents already written are left as-is.
- States: IDLE, LOAD, VERIFY, TRIGGER, DONE, ERROR.
- IDLE:
  - manual_mem=0, byte_ready=0; byte_valid is ignored.
  - start=1 -> LOAD next cycle with ptr=0 and manual_mem=1.
- LOAD:
  - byte_ready=1 throughout.
  - Each edge with byte_valid&byte_ready:
    - shadow[ptr]<=byte_in
    - mem_addr<=BASE_ADDR+ptr (mod 2^ADDR_WIDTH)
    - mem_dout<=byte_in
    - mem_we<=1
    - ptr++
  - mem_we=0 on any cycle with no handshake. Throughput is 1 byte/clk.
  - On the accept where ptr reaches LOAD_LEN-1 -> VERIFY, with byte_ready=0 from the next cycle and ptr=0.
- VERIFY:
  - Read addresses are issued back-to-back: mem_addr=BASE_ADDR+k, mem_we=0, k=0..LOAD_LEN-1.
  - Compare is one cycle behind: mem_din is checked against shadow[k-1].
  - Total duration is LOAD_LEN+1 cycles.
  - First mismatch -> ERROR immediately; error_addr=BASE_ADDR+that index.
  - All bytes match -> TRIGGER.
- TRIGGER (one cycle):
  - trigger_program=1, manual_mem=0 on this cycle.
  - -> DONE.
- DONE: done=1, manual_mem=0. Held until start=1, which clears done and re-enters LOAD.
- ERROR:
  - error=1, error_addr held, manual_mem=1 so the CPU never runs an unverified program.
  - trigger_program is never asserted.
  - start=1 clears error/error_addr and re-enters LOAD.
- start in LOAD, VERIFY or TRIGGER is ignored.
- Simultaneous start and byte_valid in IDLE: the byte is not accepted; byte_ready rises the next cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- trigger_program is asserted exactly once per successful load.

Test Plan:
- Program load: BASE_ADDR=16, LOAD_LEN=16, stream A9,04,85,02,00x12 with byte_valid held high.
  - mem_we asserted on 16 consecutive cycles, mem_addr 0x10..0x1F.
  - VERIFY lasts 17 cycles.
  - trigger_program high for exactly 1 cycle, manual_mem falls that cycle, then done=1.
- Stalled stream: byte_valid toggles 1,0,0,1,... randomly.
  - mem_we only on handshake cycles, addresses still contiguous, same final memory image.
  - Exactly 16 writes.
- Corruption: bench memory model forces address 0x12 to read 0xFF instead of 0x85.
  - error=1, error_addr=0x0012, trigger_program never asserted, manual_mem stays 1.
  - A subsequent start plus a clean reload reaches done=1.
- Reset mid-load: assert reset after 5 accepted bytes.
  - All outputs 0 in the same cycle; state IDLE.
  - A new start loads 16 bytes from address 0x10 again.
- Wrap: BASE_ADDR=0xFFF8, LOAD_LEN=16.
  - Write addresses FFF8..FFFF then 0000..0007; verify covers the same set; done=1.
- Ignored start: pulse start during LOAD and during VERIFY.
  - No restart, ptr is unaffected, trigger_program pulses once at the end.
